instruction_prefetch_buffer: RTL
================================

Name: instruction_prefetch_buffer

Overview:
- Next-generation instruction memory. A parametrised instruction store with a write/load port and an autonomous fetch PC.
- Fetches sequentially into a small FIFO and delivers {pc, instruction, fault} to the decode stage over a valid/ready handshake.
- Supports redirect (branch/jump) with full flush, and halts on misaligned or out-of-range fetches.

Parameters:
- WORDSIZE, 64: address/PC width.
- INSTRUCTION_SIZE, 32: instruction width.
- MEMORY_SIZE, 1024: number of instruction words stored.
- FIFO_DEPTH, 4: prefetch entries; power of two, at least 2.
- RESET_PC, 0: fetch PC after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_en  in  1  write one instruction word this cycle.
- load_addr  in  WORDSIZE  byte address of the write; bits [1:0] are ignored.
- load_data  in  INSTRUCTION_SIZE  word to write.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  WORDSIZE  new fetch byte address.
- out_ready  in  1  consumer accepts the head entry.
- out_valid  out  1  FIFO non-empty.
- out_instruction  out  INSTRUCTION_SIZE  head instruction.
- out_pc  out  WORDSIZE  byte address of the head instruction.
- out_fault  out  1  head entry is a fault marker.

Behaviour:
- Memory
  - Word array of MEMORY_SIZE entries, indexed by address >> 2.
  - Contents are not reset. Load writes occur on the clock edge.
  - Read-during-write to the same word in the same cycle returns the old data.
  - load_en with an index >= MEMORY_SIZE is ignored.
- Reset (async, rst_n=0)
  - Outputs: out_valid=0, out_instruction=0, out_pc=0, out_fault=0.
  - Internal: FIFO empty, fetch_pc=RESET_PC, state=FETCH.
- States
  - FETCH: each cycle in which a push is possible, a fetch occurs. A push is possible when count<FIFO_DEPTH, or the FIFO is full and a pop happens in the same cycle.
  - A fetch pushes {fetch_pc, mem[fetch_pc>>2], 0} and sets fetch_pc += 4 (wraps modulo 2^WORDSIZE).
  - If no push is possible, state moves to STALL.
  - STALL: no fetch. Returns to FETCH on the edge where a pop occurs; that same cycle's push rule still applies.
  - Fault: in FETCH, if fetch_pc[1:0]!=0 or (fetch_pc>>2)>=MEMORY_SIZE:
    - push {fetch_pc, 0, 1};
    - fetch_pc unchanged;
    - state moves to HALT.
  - HALT: no fetch until redirect. Already-queued entries drain normally.
- Latency
  - A word fetched at edge N is visible at the outputs after edge N if the FIFO was empty.
  - First out_valid=1 occurs one cycle after rst_n deasserts, i.e. after the first active edge.
  - Sustained throughput is one instruction per cycle while out_ready=1.
- Handshake
  - Pop occurs when out_valid && out_ready at the edge.
  - Outputs reflect the FIFO head combinationally from registered FIFO storage.
  - Head outputs are stable while out_valid=1 and out_ready=0.
- Redirect (highest priority)
  - On the edge with redirect=1: FIFO cleared, any pop or push that cycle discarded, fetch_pc=redirect_pc, state=FETCH.
  - out_valid=0 the following cycle; the first new entry appears one cycle after that.
  - A misaligned redirect_pc produces a fault entry as the first new entry.
- Simultaneous events
  - load_en together with redirect: the load still commits.
  - Push and pop in the same cycle leave count unchanged.
- Reset mid-operation: immediate return to the reset state; load writes in flight are lost.

Optional Feature:
- Macro: IPB_STATS_EN.
- When defined, adds outputs stat_fetched[31:0] and stat_flushes[31:0].
  - stat_fetched counts non-fault pushes.
  - stat_flushes counts redirect edges.
  - Both reset to 0 and wrap at 2^32.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Load words 0x00000013, 0x00100093, 0x00200113 at byte addresses 0, 4, 8; release reset with out_ready=1 -> (pc, instr) pairs (0, 0x00000013), (4, 0x00100093), (8, 0x00200113) on consecutive cycles, out_fault=0.
- Hold out_ready=0 for 10 cycles after reset -> out_valid=1, head stays pc=0; exactly FIFO_DEPTH=4 entries queued. Then out_ready=1 -> pcs 0, 4, 8, 12, 16 delivered with no gap.
- Mid-stream redirect to 0x40 while the FIFO is full -> out_valid=0 the next cycle, then pc=0x40 with mem[16]; no stale pc from before the redirect appears.
- Redirect to 0x42 -> a single entry {pc=0x42, instr=0, fault=1}, then out_valid=0 indefinitely. A subsequent redirect to 0 resumes at pc=0.
- Sequential fetch reaching byte address 4*MEMORY_SIZE=0x1000 -> fault entry at pc=0x1000 after the entry for 0xFFC; fetching halts.
- Assert rst_n=0 asynchronously between edges with 3 entries queued -> out_valid=0 immediately. After release, first entry is pc=RESET_PC. With IPB_STATS_EN defined, stat_fetched restarts from 0.

Source files
------------

// File: rtl/instruction_prefetch_buffer.sv
// instruction_prefetch_buffer
// Instruction store with a load port and an autonomous sequential prefetcher that queues
// {pc, instruction, fault} entries into a small FIFO for the decode stage.
// Define IPB_STATS_EN to add the stat_fetched / stat_flushes counters and ports.
module instruction_prefetch_buffer #(
   parameter int unsigned         WORDSIZE         = 64,
   parameter int unsigned         INSTRUCTION_SIZE = 32,
   parameter int unsigned         MEMORY_SIZE      = 1024,
   parameter int unsigned         FIFO_DEPTH       = 4,
   parameter logic [WORDSIZE-1:0] RESET_PC         = '0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        load_en,
   input  logic [WORDSIZE-1:0]         load_addr,
   input  logic [INSTRUCTION_SIZE-1:0] load_data,
   input  logic                        redirect,
   input  logic [WORDSIZE-1:0]         redirect_pc,
   input  logic                        out_ready,
   output logic                        out_valid,
   output logic [INSTRUCTION_SIZE-1:0] out_instruction,
   output logic [WORDSIZE-1:0]         out_pc,
   output logic                        out_fault
`ifdef IPB_STATS_EN
   ,
   output logic [31:0]                 stat_fetched,
   output logic [31:0]                 stat_flushes
`endif
);

   localparam int unsigned AW = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam logic [WORDSIZE-1:0] MEM_WORDS = WORDSIZE'(MEMORY_SIZE);
   localparam logic [PW:0]         DEPTH_C   = (PW+1)'(FIFO_DEPTH);

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_STALL = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   logic [INSTRUCTION_SIZE-1:0] mem [MEMORY_SIZE];

   logic [WORDSIZE-1:0]         load_idx;
   logic                        load_ok;
   logic [WORDSIZE-1:0]         fetch_pc;
   logic [WORDSIZE-1:0]         fetch_idx;
   logic                        fetch_fault;
   logic [INSTRUCTION_SIZE-1:0] fetch_word;
   logic [1:0]                  state;

   logic [WORDSIZE-1:0]         fifo_pc    [FIFO_DEPTH];
   logic [INSTRUCTION_SIZE-1:0] fifo_instr [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]       fifo_fault;
   logic [PW-1:0]               rd_ptr;
   logic [PW-1:0]               wr_ptr;
   logic [PW:0]                 count;

   logic pop;
   logic can_push;
   logic push;

   // Address decode for the load port and the fetch PC; out-of-range loads are dropped.
   always_comb begin
      load_idx    = load_addr >> 2;
      load_ok     = load_en && (load_idx < MEM_WORDS);
      fetch_idx   = fetch_pc >> 2;
      fetch_fault = (fetch_pc[1:0] != 2'b00) || (fetch_idx >= MEM_WORDS);
      // Asynchronous read: a same-edge load is not yet visible, so the old word is fetched.
      fetch_word  = '0;
      if (!fetch_fault) begin
         fetch_word = mem[fetch_idx[AW-1:0]];
      end
   end

   // Instruction store write port; contents are never reset.
   always_ff @(posedge clk) begin
      if (load_ok) begin
         mem[load_idx[AW-1:0]] <= load_data;
      end
   end

   // Handshake and push decision. A full FIFO still accepts a push when it pops this cycle.
   always_comb begin
      pop      = (count != '0) && out_ready;
      can_push = (count < DEPTH_C) || pop;
      push     = (state != ST_HALT) && can_push && !redirect;
   end

   // Fetch sequencer and FIFO pointers; redirect overrides everything else.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         fetch_pc <= RESET_PC;
         state    <= ST_FETCH;
      end else if (redirect) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         fetch_pc <= redirect_pc;
         state    <= ST_FETCH;
      end else begin
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (push && !pop) begin
            count <= count + (PW+1)'(1);
         end else if (!push && pop) begin
            count <= count - (PW+1)'(1);
         end
         if (push) begin
            if (fetch_fault) begin
               // Fault marker queued; PC holds until the next redirect.
               state <= ST_HALT;
            end else begin
               fetch_pc <= fetch_pc + WORDSIZE'(4);
               state    <= ST_FETCH;
            end
         end else if (state != ST_HALT) begin
            state <= ST_STALL;
         end
      end
   end

   // FIFO entry storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            fifo_pc[i]    <= '0;
            fifo_instr[i] <= '0;
         end
         fifo_fault <= '0;
      end else if (push) begin
         fifo_pc[wr_ptr]    <= fetch_pc;
         fifo_instr[wr_ptr] <= fetch_word;
         fifo_fault[wr_ptr] <= fetch_fault;
      end
   end

   // Head of the FIFO drives the decode interface; fields read as zero while empty.
   always_comb begin
      out_valid       = (count != '0);
      out_pc          = '0;
      out_instruction = '0;
      out_fault       = 1'b0;
      if (out_valid) begin
         out_pc          = fifo_pc[rd_ptr];
         out_instruction = fifo_instr[rd_ptr];
         out_fault       = fifo_fault[rd_ptr];
      end
   end

`ifdef IPB_STATS_EN
   // Statistics: non-fault pushes and redirect edges, both wrapping at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_fetched <= '0;
         stat_flushes <= '0;
      end else begin
         if (push && !fetch_fault) begin
            stat_fetched <= stat_fetched + 32'd1;
         end
         if (redirect) begin
            stat_flushes <= stat_flushes + 32'd1;
         end
      end
   end
`endif

endmodule
